// File: rtl/jrc_phase_decoder.sv
// Johnson ring counter phase decoder with revolution count, sticky error and snapshot port.
// Optional: JRC_STEP_CHECK_EN flags phase steps other than +0/+1 between legal decodes.
module jrc_phase_decoder #(
  parameter int W     = 10,
  parameter int PH_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             C,
  input  logic             R,
  input  logic [W-1:0]     Q,
  input  logic             CLR_ERR,
  input  logic             SNAP_REQ,
  input  logic             SNAP_ACK,
  output logic [PH_W-1:0]  PHASE,
  output logic             PHASE_VLD,
  output logic [CNT_W-1:0] WRAPS,
  output logic             ILLEGAL,
  output logic [PH_W-1:0]  SNAP_PHASE,
  output logic [CNT_W-1:0] SNAP_WRAPS,
  output logic             SNAP_VALID
);

  localparam logic [PH_W-1:0] LAST = PH_W'(2 * W - 1);

  typedef enum logic {
    IDLE,
    HELD
  } snap_st_e;

  logic [W-1:0]     q_q;
  logic             qv_q;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] wr_q, wr_d;
  logic             ill_q, ill_d;
  logic [PH_W-1:0]  sph_q;
  logic [CNT_W-1:0] swr_q;
  snap_st_e         st_q, st_d;
  logic             snap_ld;
  logic [PH_W-1:0]  dec_ph;
  logic             dec_ok;
  logic             bad;

  function automatic logic [W-1:0] low_ones(input int k);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = (i < k);
    return r;
  endfunction

  // Stage 1: register the incoming code; qv_q marks real data after reset
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      q_q  <= '0;
      qv_q <= 1'b0;
    end else begin
      q_q  <= Q;
      qv_q <= 1'b1;
    end
  end

  // Thermometer-style match against all 2W legal Johnson codes
  always_comb begin
    dec_ok = 1'b0;
    dec_ph = '0;
    for (int k = 0; k <= W; k++) begin
      if (q_q == low_ones(k)) begin
        dec_ok = 1'b1;
        dec_ph = PH_W'(k);
      end
    end
    for (int j = 1; j < W; j++) begin
      if (q_q == ~low_ones(j)) begin
        dec_ok = 1'b1;
        dec_ph = PH_W'(W + j);
      end
    end
  end

`ifdef JRC_STEP_CHECK_EN
  logic [PH_W-1:0] ph_inc;
  logic            step_bad;

  // Successor phase and step legality between consecutive legal decodes
  always_comb begin
    ph_inc   = (ph_q == LAST) ? '0 : ph_q + 1'b1;
    step_bad = qv_q && dec_ok && vld_q &&
               (dec_ph != ph_q) && (dec_ph != ph_inc);
  end
`endif

  // Stage 2 next state: phase hold on illegal, wrap pairing, sticky error
  always_comb begin
    vld_d = qv_q && dec_ok;
    ph_d  = vld_d ? dec_ph : ph_q;
    wr_d  = wr_q;
    if (vld_d && dec_ph == '0 && vld_q && ph_q == LAST)
      wr_d = wr_q + 1'b1;
`ifdef JRC_STEP_CHECK_EN
    bad = (qv_q && !dec_ok) || step_bad;
`else
    bad = qv_q && !dec_ok;
`endif
    ill_d = ill_q;
    if (bad)
      ill_d = 1'b1;
    else if (CLR_ERR)
      ill_d = 1'b0;
  end

  // Stage 2 registers
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      ph_q  <= '0;
      vld_q <= 1'b0;
      wr_q  <= '0;
      ill_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      vld_q <= vld_d;
      wr_q  <= wr_d;
      ill_q <= ill_d;
    end
  end

  // Snapshot FSM: REQ ignored while held, ACK ignored while idle
  always_comb begin
    st_d    = st_q;
    snap_ld = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (SNAP_REQ) begin
          st_d    = HELD;
          snap_ld = 1'b1;
        end
      end
      HELD: begin
        if (SNAP_ACK) st_d = IDLE;
      end
    endcase
  end

  // Snapshot state and captured pre-update phase/wraps
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      st_q  <= IDLE;
      sph_q <= '0;
      swr_q <= '0;
    end else begin
      st_q <= st_d;
      if (snap_ld) begin
        sph_q <= ph_q;
        swr_q <= wr_q;
      end
    end
  end

  assign PHASE      = ph_q;
  assign PHASE_VLD  = vld_q;
  assign WRAPS      = wr_q;
  assign ILLEGAL    = ill_q;
  assign SNAP_PHASE = sph_q;
  assign SNAP_WRAPS = swr_q;
  assign SNAP_VALID = (st_q == HELD);

endmodule

// File: tb/tb_jrc_phase_decoder.sv
// Directed bench for jrc_phase_decoder.
// Second instance with CNT_W=4 shares all inputs to check the wrap-count rollover.
module tb_jrc_phase_decoder;

  logic        C = 1'b0;
  logic        R;
  logic [9:0]  Q;
  logic        CLR_ERR, SNAP_REQ, SNAP_ACK;
  logic [4:0]  PHASE, SNAP_PHASE;
  logic        PHASE_VLD, ILLEGAL, SNAP_VALID;
  logic [15:0] WRAPS, SNAP_WRAPS;
  logic [4:0]  ph4, sph4;
  logic        vld4, ill4, sv4;
  logic [3:0]  wr4, swr4;

  int nvec = 0;
  int nerr = 0;
  int p;

  always #5 C = ~C;

  jrc_phase_decoder dut (
    .C(C), .R(R), .Q(Q), .CLR_ERR(CLR_ERR),
    .SNAP_REQ(SNAP_REQ), .SNAP_ACK(SNAP_ACK),
    .PHASE(PHASE), .PHASE_VLD(PHASE_VLD),
    .WRAPS(WRAPS), .ILLEGAL(ILLEGAL),
    .SNAP_PHASE(SNAP_PHASE), .SNAP_WRAPS(SNAP_WRAPS),
    .SNAP_VALID(SNAP_VALID)
  );

  jrc_phase_decoder #(.CNT_W(4)) dut4 (
    .C(C), .R(R), .Q(Q), .CLR_ERR(CLR_ERR),
    .SNAP_REQ(SNAP_REQ), .SNAP_ACK(SNAP_ACK),
    .PHASE(ph4), .PHASE_VLD(vld4),
    .WRAPS(wr4), .ILLEGAL(ill4),
    .SNAP_PHASE(sph4), .SNAP_WRAPS(swr4),
    .SNAP_VALID(sv4)
  );

  function automatic logic [9:0] code(input int ph);
    logic [9:0] r;
    for (int i = 0; i < 10; i++)
      r[i] = (ph <= 10) ? (i < ph) : (i >= ph - 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge C);
    #1;
  endtask

  initial begin
    R = 1'b1; Q = '0;
    CLR_ERR = 0; SNAP_REQ = 0; SNAP_ACK = 0;
    #3;
    chk("rst_phase", 32'(PHASE), 0);
    chk("rst_vld", 32'(PHASE_VLD), 0);
    chk("rst_wraps", 32'(WRAPS), 0);
    chk("rst_snapv", 32'(SNAP_VALID), 0);
    #9 R = 1'b0;

    // 1: one full revolution plus return to phase 0
    for (int n = 0; n <= 21; n++) begin
      Q = code(n % 20);
      tick();
      if (n == 0) chk("first_vld", 32'(PHASE_VLD), 0);
      else begin
        chk("rev_phase", 32'(PHASE), 32'((n - 1) % 20));
        chk("rev_vld", 32'(PHASE_VLD), 1);
      end
      if (n == 20) chk("wraps_pre", 32'(WRAPS), 0);
    end
    chk("wraps_one", 32'(WRAPS), 1);
    chk("ill_none", 32'(ILLEGAL), 0);

    // 2: illegal code, sticky flag, set-beats-clear
    Q = 10'h005; tick();
    Q = code(2); tick();
    chk("ill_vld", 32'(PHASE_VLD), 0);
    chk("ill_hold", 32'(PHASE), 1);
    chk("ill_set", 32'(ILLEGAL), 1);
    Q = code(3); tick();
    chk("ill_sticky", 32'(ILLEGAL), 1);
    chk("ill_recov", 32'(PHASE), 2);
    Q = 10'h005; tick();
    Q = code(4); CLR_ERR = 1; tick();
    chk("ill_setwins", 32'(ILLEGAL), 1);
    chk("ill_hold2", 32'(PHASE), 3);
    Q = code(5); tick();
    CLR_ERR = 0;
    chk("ill_clr", 32'(ILLEGAL), 0);
    chk("clr_phase", 32'(PHASE), 4);

    // 3: advance to phase 7 with WRAPS=3, then snapshot handshake
    p = 6;
    for (int n = 0; n < 43; n++) begin
      Q = code(p % 20); p++; tick();
    end
    chk("pre_snap_ph", 32'(PHASE), 7);
    chk("pre_snap_wr", 32'(WRAPS), 3);
    chk("ill_stepok", 32'(ILLEGAL), 0);
    Q = code(p % 20); p++; SNAP_REQ = 1; tick();
    chk("snap_v", 32'(SNAP_VALID), 1);
    chk("snap_ph", 32'(SNAP_PHASE), 7);
    chk("snap_wr", 32'(SNAP_WRAPS), 3);
    Q = code(p % 20); p++; tick();
    chk("snap_ign_ph", 32'(SNAP_PHASE), 7);
    chk("snap_ign_v", 32'(SNAP_VALID), 1);
    Q = code(p % 20); p++; SNAP_ACK = 1; tick();
    chk("snap_ackwin", 32'(SNAP_VALID), 0);
    chk("snap_holdph", 32'(SNAP_PHASE), 7);
    Q = code(p % 20); p++; SNAP_REQ = 0; SNAP_ACK = 0; tick();
    chk("snap_dropped", 32'(SNAP_VALID), 0);
    Q = code(p % 20); p++; SNAP_ACK = 1; tick();
    chk("snap_ackidle", 32'(SNAP_VALID), 0);
    Q = code(p % 20); p++; SNAP_ACK = 0; SNAP_REQ = 1; tick();
    SNAP_REQ = 0;
    chk("snap2_v", 32'(SNAP_VALID), 1);
    chk("snap2_ph", 32'(SNAP_PHASE), 12);
    chk("phase13", 32'(PHASE), 13);

    // 4: reach 16 revolutions; 4-bit counter rolls to 0
    for (int n = 0; n < 247; n++) begin
      Q = code(p % 20); p++; tick();
    end
    chk("wraps16", 32'(WRAPS), 16);
    chk("wraps4_roll", 32'(wr4), 0);
    chk("phase_at16", 32'(PHASE), 0);
    chk("snap_kept", 32'(SNAP_WRAPS), 3);

    // 5: async reset with snapshot held and error set
    Q = 10'h005; tick();
    Q = code(0); tick();
    chk("pre_rst_ill", 32'(ILLEGAL), 1);
    chk("pre_rst_sv", 32'(SNAP_VALID), 1);
    #2 R = 1'b1;
    #1;
    chk("arst_ill", 32'(ILLEGAL), 0);
    chk("arst_sv", 32'(SNAP_VALID), 0);
    chk("arst_wr", 32'(WRAPS), 0);
    chk("arst_sph", 32'(SNAP_PHASE), 0);
    chk("arst_swr", 32'(SNAP_WRAPS), 0);
    chk("arst_ph", 32'({PHASE, PHASE_VLD}), 0);

    // 6: phase jump 1 -> 4
    Q = code(1);
    #2 R = 1'b0;
    tick();
    Q = code(4); tick();
    chk("jump_from", 32'(PHASE), 1);
    tick();
    chk("jump_ph", 32'(PHASE), 4);
    chk("jump_vld", 32'(PHASE_VLD), 1);
`ifdef JRC_STEP_CHECK_EN
    chk("jump_ill", 32'(ILLEGAL), 1);
`else
    chk("jump_ill", 32'(ILLEGAL), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
